// File: rtl/integrate_decimate.sv
// integrate_decimate: integrator plus decimator stage of the PDM front-end.
// Accumulates signed comb-stage samples into a wrap-around accumulator and
// presents every DECIM-th accumulator value with a single-cycle valid pulse.
// Widths must satisfy DECIM >= 2 and I_BW <= O_BW.
module integrate_decimate #(
    parameter int I_BW  = 3,
    parameter int O_BW  = 8,
    parameter int DECIM = 250
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o
);

    localparam int              CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    // Dropping the enable behaves exactly like a reset, so both share one clear.
    logic clear;
    assign clear = rst_i | ~en_i;

    // The sample is sign-extended so a -1 from the comb wraps the accumulator down.
    logic signed [I_BW-1:0] data_s;
    logic        [O_BW-1:0] data_ext;
    assign data_s   = data_i;
    assign data_ext = O_BW'(data_s);

    logic [O_BW-1:0]  acc_q, acc_d;
    logic             int_valid_q, int_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [O_BW-1:0]  data_q, data_d;
    logic             valid_q, valid_d;

    // Integrator: add each accepted sample modulo 2^O_BW and flag it for the decimator.
    always_comb begin
        acc_d       = acc_q;
        int_valid_d = valid_i;
        if (clear) begin
            acc_d       = '0;
            int_valid_d = 1'b0;
        end else if (valid_i) begin
            acc_d = acc_q + data_ext;
        end
    end

    // Decimator: count flagged samples and publish the accumulator on every DECIM-th one.
    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (int_valid_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                data_d  = acc_q;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            int_valid_q <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            int_valid_q <= int_valid_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_integrate_decimate.sv
// Testbench for integrate_decimate: directed and random stimulus, a sample-count
// reference model feeding a scoreboard queue, and a decoupled output monitor.
module tb_integrate_decimate;

    localparam int I_BW  = 3;
    localparam int O_BW  = 8;
    localparam int DECIM = 250;

    logic            clk;
    logic            rst_i;
    logic            en_i;
    logic [I_BW-1:0] data_i;
    logic            valid_i;
    logic [O_BW-1:0] data_o;
    logic            valid_o;

    integrate_decimate #(.I_BW(I_BW), .O_BW(O_BW), .DECIM(DECIM)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .data_o (data_o),
        .valid_o(valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             pulse_edge;
        logic [O_BW-1:0] val;
    } exp_t;

    exp_t            exp_q[$];
    int              edge_cnt   = 0;
    int              compared   = 0;
    int              mismatched = 0;
    bit              active     = 1'b0;
    logic [O_BW-1:0] exp_hold   = '0;

    // Reference model state: accepted samples and their plain integer sum since the last clear.
    int n_samples = 0;
    int run_sum   = 0;

    // Drive one cycle of inputs, then update the reference model for that edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit vld, input int d);
        @(negedge clk);
        rst_i   = rst;
        en_i    = en;
        valid_i = vld;
        data_i  = I_BW'(d);
        @(posedge clk);
        edge_cnt++;
        if (rst || !en) begin
            exp_q.delete();
            n_samples = 0;
            run_sum   = 0;
            exp_hold  = '0;
        end else if (vld) begin
            exp_t e;
            n_samples++;
            run_sum += d;
            if (n_samples % DECIM == 0) begin
                e.pulse_edge = edge_cnt + 1;
                e.val        = O_BW'(run_sum & ((1 << O_BW) - 1));
                exp_q.push_back(e);
            end
        end
        active = 1'b1;
    endtask

    // Monitor: every cycle, a due expectation must appear as a pulse; otherwise outputs must idle.
    always @(negedge clk) begin
        if (active) begin
            if (exp_q.size() > 0 && exp_q[0].pulse_edge == edge_cnt) begin
                compared++;
                if (valid_o !== 1'b1 || data_o !== exp_q[0].val) begin
                    mismatched++;
                    $display("[TB] FAIL pulse@%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                             edge_cnt, valid_o, data_o, exp_q[0].val);
                end
                exp_hold = exp_q[0].val;
                void'(exp_q.pop_front());
            end else begin
                compared++;
                if (valid_o !== 1'b0 || data_o !== exp_hold) begin
                    mismatched++;
                    $display("[TB] FAIL idle@%0d: got valid=%b data=%0d, want valid=0 data=%0d",
                             edge_cnt, valid_o, data_o, exp_hold);
                end
            end
        end
    end

    task automatic run_const(input int cycles, input int d);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1);
    endtask

    // Final check: nothing the model expected may remain unobserved.
    task automatic checkOutput();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending pulses, want 0", exp_q.size());
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;

        // Reset held with live input: outputs must stay zero.
        do_reset(8);

        // +1 continuous: 250 then 244.
        run_const(505, 1);

        // -1 continuous: 6 then 12.
        do_reset(2);
        run_const(505, -1);

        // Alternating +1/-1, then all-zero.
        do_reset(2);
        for (int i = 0; i < 505; i++) applyStimulus(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 1 : -1);
        run_const(255, 0);

        // Sparse valid: one accepted +1 every 4th cycle.
        do_reset(2);
        for (int i = 0; i < 1010; i++) applyStimulus(1'b0, 1'b1, (i % 4 == 0), 1);

        // Enable drop mid-frame discards the partial sum.
        do_reset(2);
        run_const(100, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        run_const(255, 1);

        // Reset mid-frame behaves identically.
        run_const(100, 1);
        do_reset(1);
        run_const(255, 1);

        // Random stimulus with occasional clears, including full-range samples.
        for (int i = 0; i < 4000; i++) begin
            int  d;
            bit  vld;
            bit  rst;
            bit  en;
            vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 7)) - 4;
            else                           d = int'($urandom_range(0, 2)) - 1;
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 999) != 0);
            applyStimulus(rst, en, vld, d);
        end

        // Let any in-flight pulse emerge, then drain.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
